// File: rtl/adder_rs_if.sv
// Issue-side request and result-broadcast bundle of the adder reservation-station unit.
// The issue stage drives the master side; the unit implements the slave side.
interface adder_rs_if;
   logic        issue;
   logic [5:0]  operation;
   logic [2:0]  execution_unit;
   logic [4:0]  Dest_address;
   logic [4:0]  A_address;
   logic [4:0]  B_address;
   logic        adder_available;
   logic [5:0]  adder_RS_available;
   logic        issue_error;
   logic [5:0]  RS_issued;
   logic [5:0]  RS_executing_adder;
   logic        adder_rts;
   logic [5:0]  RS_finished;
   logic [31:0] result_value;
   logic [4:0]  result_dest;

   modport master (
      output issue, operation, execution_unit, Dest_address, A_address, B_address,
      input  adder_available, adder_RS_available, issue_error, RS_issued,
             RS_executing_adder, adder_rts, RS_finished, result_value, result_dest
   );

   modport slave (
      input  issue, operation, execution_unit, Dest_address, A_address, B_address,
      output adder_available, adder_RS_available, issue_error, RS_issued,
             RS_executing_adder, adder_rts, RS_finished, result_value, result_dest
   );
endinterface

// File: rtl/adder_rs_unit.sv
// Tomasulo-style adder reservation stations with register file, register status table
// and a single multi-cycle adder that broadcasts one result per writeback.
module adder_rs_unit #(
   parameter int NUM_RS        = 3,
   parameter int ADDER_LATENCY = 2
) (
   input  logic      clock,
   input  logic      reset_n,
   adder_rs_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   localparam int         IDX_W      = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam int         CNT_INIT_I = (ADDER_LATENCY > 1) ? ADDER_LATENCY - 2 : 0;
   localparam logic [1:0] CNT_INIT   = 2'(CNT_INIT_I);

   logic             busy   [NUM_RS];
   logic             disp   [NUM_RS];
   logic [2:0]       op_q   [NUM_RS];
   logic [4:0]       dest_q [NUM_RS];
   logic [31:0]      vj     [NUM_RS];
   logic [31:0]      vk     [NUM_RS];
   logic [5:0]       qj     [NUM_RS];
   logic [5:0]       qk     [NUM_RS];
   logic [31:0]      regs   [32];
   logic [5:0]       status [32];

   state_t           state, state_nxt;
   logic [1:0]       cnt;
   logic [5:0]       ex_tag;
   logic [4:0]       ex_dest;
   logic [31:0]      ex_val;

   logic             free_any, rdy_any, dispatch, wb_fire, issue_ok, issue_bad;
   logic [IDX_W-1:0] free_idx, rdy_idx;
   logic [5:0]       src_a_q, src_b_q;
   logic [31:0]      src_a_v, src_b_v;
   logic             unused_unit_code;

   function automatic logic [5:0] tag_of(input logic [2:0] k);
      return 6'd1 << k;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:  alu = a + b;
         3'b001:  alu = a - b;
         3'b100:  alu = a | b;
         3'b101:  alu = a & b;
         3'b110:  alu = ~a;
         3'b111:  alu = a ^ b;
         default: alu = 32'd0;
      endcase
   endfunction

   // The unit code in operation[5:3] is redundant with execution_unit, which alone selects the adder.
   assign unused_unit_code = ^bus.operation[5:3];

   assign wb_fire   = (state == S_WB);
   assign issue_ok  = bus.issue && (bus.execution_unit == 3'b000) && free_any;
   assign issue_bad = bus.issue && !issue_ok;

   assign bus.adder_available    = free_any;
   assign bus.adder_RS_available = free_any ? tag_of(3'(free_idx)) : 6'd0;

   // Lowest-index free station and lowest-index dispatchable station, both from pre-edge state.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      rdy_any  = 1'b0;
      rdy_idx  = '0;
      for (int k = NUM_RS - 1; k >= 0; k--) begin
         if (!busy[k]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(k);
         end
         if (busy[k] && !disp[k] && (qj[k] == 6'd0) && (qk[k] == 6'd0)) begin
            rdy_any = 1'b1;
            rdy_idx = IDX_W'(k);
         end
      end
   end

   // A writeback on the issue edge satisfies a source that is still waiting on its tag.
   always_comb begin
      src_a_q = status[bus.A_address];
      src_a_v = regs[bus.A_address];
      src_b_q = status[bus.B_address];
      src_b_v = regs[bus.B_address];
      if (wb_fire && (src_a_q != 6'd0) && (src_a_q == ex_tag)) begin
         src_a_q = 6'd0;
         src_a_v = ex_val;
      end
      if (wb_fire && (src_b_q != 6'd0) && (src_b_q == ex_tag)) begin
         src_b_q = 6'd0;
         src_b_v = ex_val;
      end
   end

   always_comb begin
      state_nxt = state;
      dispatch  = 1'b0;
      case (state)
         S_IDLE: begin
            if (rdy_any) begin
               dispatch  = 1'b1;
               state_nxt = (ADDER_LATENCY > 1) ? S_EXEC : S_WB;
            end
         end
         S_EXEC:  if (cnt == 2'd0) state_nxt = S_WB;
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_RS; k++) begin
            busy[k]   <= 1'b0;
            disp[k]   <= 1'b0;
            op_q[k]   <= 3'd0;
            dest_q[k] <= 5'd0;
            vj[k]     <= 32'd0;
            vk[k]     <= 32'd0;
            qj[k]     <= 6'd0;
            qk[k]     <= 6'd0;
         end
         for (int i = 0; i < 32; i++) begin
            regs[i]   <= 32'(i);
            status[i] <= 6'd0;
         end
         cnt                    <= 2'd0;
         ex_tag                 <= 6'd0;
         ex_dest                <= 5'd0;
         ex_val                 <= 32'd0;
         bus.issue_error        <= 1'b0;
         bus.RS_issued          <= 6'd0;
         bus.RS_executing_adder <= 6'd0;
         bus.adder_rts          <= 1'b0;
         bus.RS_finished        <= 6'd0;
         bus.result_value       <= 32'd0;
         bus.result_dest        <= 5'd0;
      end else begin
         bus.issue_error        <= issue_bad;
         bus.RS_issued          <= issue_ok ? tag_of(3'(free_idx)) : 6'd0;
         bus.RS_executing_adder <= dispatch ? tag_of(3'(rdy_idx)) : 6'd0;
         bus.adder_rts          <= wb_fire;
         bus.RS_finished        <= wb_fire ? ex_tag : 6'd0;
         bus.result_value       <= wb_fire ? ex_val : 32'd0;
         bus.result_dest        <= wb_fire ? ex_dest : 5'd0;

         if (state == S_EXEC) cnt <= cnt - 2'd1;

         // Dispatch: the result is computed here and held until writeback.
         if (dispatch) begin
            cnt           <= CNT_INIT;
            ex_tag        <= tag_of(3'(rdy_idx));
            ex_dest       <= dest_q[rdy_idx];
            ex_val        <= alu(op_q[rdy_idx], vj[rdy_idx], vk[rdy_idx]);
            disp[rdy_idx] <= 1'b1;
         end

         // Writeback: commit, wake up waiters, release the producing station.
         if (wb_fire) begin
            regs[ex_dest] <= ex_val;
            if (status[ex_dest] == ex_tag) status[ex_dest] <= 6'd0;
            for (int k = 0; k < NUM_RS; k++) begin
               if (busy[k] && (qj[k] == ex_tag)) begin
                  vj[k] <= ex_val;
                  qj[k] <= 6'd0;
               end
               if (busy[k] && (qk[k] == ex_tag)) begin
                  vk[k] <= ex_val;
                  qk[k] <= 6'd0;
               end
               if (tag_of(3'(k)) == ex_tag) begin
                  busy[k] <= 1'b0;
                  disp[k] <= 1'b0;
               end
            end
         end

         // Issue comes last so a same-edge rename of the destination wins over the status clear.
         if (issue_ok) begin
            busy[free_idx]   <= 1'b1;
            disp[free_idx]   <= 1'b0;
            op_q[free_idx]   <= bus.operation[2:0];
            dest_q[free_idx] <= bus.Dest_address;
            vj[free_idx]     <= src_a_v;
            qj[free_idx]     <= src_a_q;
            vk[free_idx]     <= src_b_v;
            qk[free_idx]     <= src_b_q;
            status[bus.Dest_address] <= tag_of(3'(free_idx));
         end
      end
   end
endmodule

// File: tb/tb_adder_rs_unit.sv
// Self-checking bench for adder_rs_unit: broadcast scoreboard, ALU vector table,
// and hand-written sequences for hazards, full stations, rejects and mid-operation reset.
module tb_adder_rs_unit;
   logic clock = 1'b0;
   logic reset_n;

   adder_rs_if bus();

   adder_rs_unit #(.NUM_RS(3), .ADDER_LATENCY(2)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]  tag;
      logic [31:0] value;
      logic [4:0]  dest;
   } bcast_t;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  d;
      logic [31:0] exp;
   } vec_t;

   bcast_t sb[$];
   bcast_t mon_e;
   vec_t   tbl[12];
   int     n_vec = 0;
   int     n_bad = 0;

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_OR  = 3'b100,
                          OP_AND = 3'b101, OP_NOT = 3'b110, OP_XOR = 3'b111;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_issue(input logic [2:0] op, input logic [4:0] d, input logic [4:0] a,
                           input logic [4:0] b, input logic [2:0] unit);
      bus.operation      = {3'b000, op};
      bus.execution_unit = unit;
      bus.Dest_address   = d;
      bus.A_address      = a;
      bus.B_address      = b;
      bus.issue          = 1'b1;
      @(posedge clock);
      #1;
      bus.issue          = 1'b0;
   endtask

   task automatic expect_bc(input logic [5:0] tag, input logic [31:0] value, input logic [4:0] dest);
      bcast_t e;
      e.tag   = tag;
      e.value = value;
      e.dest  = dest;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 60) begin
         step(1);
         t++;
      end
      chk({name, " pending broadcasts"}, 32'(sb.size()), 32'd0);
      sb.delete();
      step(2);
      chk({name, " all stations free"}, 32'(bus.adder_RS_available), 32'd1);
   endtask

   // Broadcast monitor: every adder_rts must match the oldest expected result.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && bus.adder_rts === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious adder_rts", 32'(bus.adder_rts), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("bcast RS_finished", 32'(bus.RS_finished), 32'(mon_e.tag));
            chk("bcast result_value", bus.result_value, mon_e.value);
            chk("bcast result_dest", 32'(bus.result_dest), 32'(mon_e.dest));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Registers start at R[i]=i; table destinations stay clear of the sources used later.
      tbl[0]  = '{OP_ADD,  5'd9,  5'd10, 5'd16, 32'd19};
      tbl[1]  = '{OP_SUB,  5'd10, 5'd9,  5'd17, 32'd1};
      tbl[2]  = '{OP_SUB,  5'd9,  5'd10, 5'd18, 32'hFFFF_FFFF};
      tbl[3]  = '{OP_OR,   5'd12, 5'd10, 5'd19, 32'd14};
      tbl[4]  = '{OP_AND,  5'd12, 5'd10, 5'd20, 32'd8};
      tbl[5]  = '{OP_NOT,  5'd8,  5'd0,  5'd21, 32'hFFFF_FFF7};
      tbl[6]  = '{OP_XOR,  5'd12, 5'd10, 5'd22, 32'd6};
      tbl[7]  = '{3'b010,  5'd9,  5'd10, 5'd23, 32'd0};
      tbl[8]  = '{3'b011,  5'd9,  5'd10, 5'd24, 32'd0};
      tbl[9]  = '{OP_ADD,  5'd21, 5'd9,  5'd25, 32'd0};
      tbl[10] = '{OP_ADD,  5'd18, 5'd18, 5'd26, 32'hFFFF_FFFE};
      tbl[11] = '{OP_SUB,  5'd0,  5'd9,  5'd27, 32'hFFFF_FFF7};

      reset_n            = 1'b0;
      bus.issue          = 1'b0;
      bus.operation      = 6'd0;
      bus.execution_unit = 3'd0;
      bus.Dest_address   = 5'd0;
      bus.A_address      = 5'd0;
      bus.B_address      = 5'd0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset adder_available", 32'(bus.adder_available), 32'd1);
      chk("reset adder_RS_available", 32'(bus.adder_RS_available), 32'd1);
      chk("reset issue_error", 32'(bus.issue_error), 32'd0);
      chk("reset RS_issued", 32'(bus.RS_issued), 32'd0);
      chk("reset RS_executing_adder", 32'(bus.RS_executing_adder), 32'd0);
      chk("reset adder_rts", 32'(bus.adder_rts), 32'd0);
      chk("reset result_value", bus.result_value, 32'd0);
      #3 reset_n = 1'b1;
      step(1);

      // Single add with exact latency
      do_issue(OP_ADD, 5'd2, 5'd1, 5'd4, 3'b000);
      expect_bc(6'b000001, 32'd5, 5'd2);
      chk("add RS_issued", 32'(bus.RS_issued), 32'h01);
      step(1);
      chk("add RS_executing_adder", 32'(bus.RS_executing_adder), 32'h01);
      step(1);
      chk("add rts early", 32'(bus.adder_rts), 32'd0);
      step(1);
      chk("add rts on time", 32'(bus.adder_rts), 32'd1);
      chk("add RS_finished", 32'(bus.RS_finished), 32'h01);
      drain("single add");

      // RAW dependency through the status table
      do_issue(OP_ADD, 5'd2, 5'd1, 5'd4, 3'b000);
      expect_bc(6'b000001, 32'd5, 5'd2);
      chk("raw first RS_issued", 32'(bus.RS_issued), 32'h01);
      do_issue(OP_ADD, 5'd3, 5'd2, 5'd7, 3'b000);
      expect_bc(6'b000010, 32'd12, 5'd3);
      chk("raw second RS_issued", 32'(bus.RS_issued), 32'h02);
      drain("raw");

      for (int i = 0; i < 12; i++) begin
         do_issue(tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, 3'b000);
         expect_bc(6'b000001, tbl[i].exp, tbl[i].d);
         chk("table RS_issued", 32'(bus.RS_issued), 32'h01);
         drain("table");
      end

      // Fill all three stations, fourth issue is rejected
      do_issue(OP_ADD, 5'd16, 5'd8, 5'd9, 3'b000);
      expect_bc(6'b000001, 32'd17, 5'd16);
      chk("full tag0", 32'(bus.RS_issued), 32'h01);
      do_issue(OP_ADD, 5'd17, 5'd10, 5'd11, 3'b000);
      expect_bc(6'b000010, 32'd21, 5'd17);
      chk("full tag1", 32'(bus.RS_issued), 32'h02);
      do_issue(OP_ADD, 5'd18, 5'd12, 5'd13, 3'b000);
      expect_bc(6'b000100, 32'd25, 5'd18);
      chk("full tag2", 32'(bus.RS_issued), 32'h04);
      chk("full adder_RS_available", 32'(bus.adder_RS_available), 32'd0);
      chk("full adder_available", 32'(bus.adder_available), 32'd0);
      do_issue(OP_ADD, 5'd19, 5'd14, 5'd15, 3'b000);
      chk("full issue_error", 32'(bus.issue_error), 32'd1);
      chk("full reject RS_issued", 32'(bus.RS_issued), 32'd0);
      step(1);
      chk("full issue_error pulse", 32'(bus.issue_error), 32'd0);
      drain("full");

      // Dispatch order is lowest index first
      do_issue(OP_SUB, 5'd5, 5'd4, 5'd1, 3'b000);
      expect_bc(6'b000001, 32'd3, 5'd5);
      do_issue(OP_NOT, 5'd6, 5'd0, 5'd0, 3'b000);
      expect_bc(6'b000010, 32'hFFFF_FFFF, 5'd6);
      chk("order second tag", 32'(bus.RS_issued), 32'h02);
      drain("order");

      // Wrong execution unit
      do_issue(OP_ADD, 5'd7, 5'd1, 5'd1, 3'b001);
      chk("unit issue_error", 32'(bus.issue_error), 32'd1);
      chk("unit RS_issued", 32'(bus.RS_issued), 32'd0);
      chk("unit adder_available", 32'(bus.adder_available), 32'd1);
      chk("unit adder_RS_available", 32'(bus.adder_RS_available), 32'd1);
      step(4);

      // Consumer issued on the producer's writeback edge: forwarded, and the freed station not reused
      do_issue(OP_ADD, 5'd28, 5'd8, 5'd9, 3'b000);
      expect_bc(6'b000001, 32'd17, 5'd28);
      step(2);
      do_issue(OP_ADD, 5'd29, 5'd28, 5'd10, 3'b000);
      expect_bc(6'b000010, 32'd27, 5'd29);
      chk("fwd RS_issued", 32'(bus.RS_issued), 32'h02);
      drain("forward");

      // R0 is an ordinary register
      do_issue(OP_ADD, 5'd0, 5'd9, 5'd10, 3'b000);
      expect_bc(6'b000001, 32'd19, 5'd0);
      drain("r0 write");
      do_issue(OP_ADD, 5'd30, 5'd0, 5'd0, 3'b000);
      expect_bc(6'b000001, 32'd38, 5'd30);
      drain("r0 read");

      // Reset in the middle of execution
      do_issue(OP_ADD, 5'd2, 5'd1, 5'd4, 3'b000);
      step(1);
      chk("midreset executing", 32'(bus.RS_executing_adder), 32'h01);
      reset_n = 1'b0;
      #1;
      chk("midreset RS_executing_adder", 32'(bus.RS_executing_adder), 32'd0);
      chk("midreset adder_rts", 32'(bus.adder_rts), 32'd0);
      chk("midreset RS_finished", 32'(bus.RS_finished), 32'd0);
      chk("midreset result_dest", 32'(bus.result_dest), 32'd0);
      step(2);
      #3 reset_n = 1'b1;
      #1;
      chk("post reset adder_available", 32'(bus.adder_available), 32'd1);
      chk("post reset adder_RS_available", 32'(bus.adder_RS_available), 32'd1);
      step(6);
      do_issue(OP_ADD, 5'd31, 5'd2, 5'd0, 3'b000);
      expect_bc(6'b000001, 32'd2, 5'd31);
      drain("post reset R2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
